// File: rtl/hex_input_pkg.sv
// Shared types and constants for the player-input front-end.
package hex_input_pkg;

  localparam int unsigned NUM_PLAYERS = 4;
  localparam int unsigned PLAYER_W    = 2;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_CAPTURED = 2'd2,
    ST_TIMEDOUT = 2'd3
  } arb_state_e;

  // Index of the lowest set request bit (0 when none are set).
  function automatic logic [PLAYER_W-1:0] first_player(input logic [NUM_PLAYERS-1:0] req);
    first_player = '0;
    for (int unsigned i = NUM_PLAYERS; i > 0; i--) begin
      if (req[i-1]) first_player = PLAYER_W'(i - 1);
    end
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a counting debouncer with rising-edge pulse.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          rise_q,  rise_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  // Count consecutive synchronized samples that disagree with the accepted level.
  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
    level_d = level_q;
    rise_d  = 1'b0;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
        rise_d  = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Synchronizer, debounce state and edge pulse registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/player_input_arbiter.sv
// Buzzer arbiter: conditions player buttons, picks the first player while armed,
// freezes player index and switch value, holds flag/timeout until cleared.
module player_input_arbiter
  import hex_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_PLAYERS-1:0] btn,
  input  logic [7:0]             sw,
  input  logic                   arm,
  input  logic                   clear,
  output logic                   playerInputFlag,
  output logic [PLAYER_W-1:0]    firstPlayerFlag,
  output logic [7:0]             switchInput,
  output logic                   timeout,
  output logic [1:0]             state_dbg
);

  localparam int unsigned WW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WIN_LAST = WW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [NUM_PLAYERS-1:0] press;
  // Debounced levels are not needed past the edge detector.
  logic [NUM_PLAYERS-1:0] unused_level;

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_btn
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[g]),
      .level (unused_level[g]),
      .rise  (press[g])
    );
  end

  logic [7:0]          sw_s1_q, sw_s1_d;
  logic [7:0]          sw_s2_q, sw_s2_d;
  arb_state_e          state_q, state_d;
  logic                flag_q,  flag_d;
  logic                to_q,    to_d;
  logic [PLAYER_W-1:0] fp_q,    fp_d;
  logic [7:0]          swv_q,   swv_d;
  logic [WW-1:0]       win_q,   win_d;

  // Next-state, capture and window-counter logic; outputs follow the next state.
  always_comb begin
    sw_s1_d = sw;
    sw_s2_d = sw_s1_q;
    state_d = state_q;
    fp_d    = fp_q;
    swv_d   = swv_q;
    win_d   = win_q;
    unique case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d = ST_ARMED;
          win_d   = '0;
        end
      end
      ST_ARMED: begin
        if (|press) begin
          state_d = ST_CAPTURED;
          fp_d    = first_player(press);
          swv_d   = sw_s2_q;
        end else if (TIMEOUT_CYCLES != 0 && win_q == WIN_LAST) begin
          state_d = ST_TIMEDOUT;
        end else if (arm) begin
          win_d = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          win_d = win_q + 1'b1;
        end
      end
      ST_CAPTURED: begin
        if (clear) state_d = ST_IDLE;
      end
      ST_TIMEDOUT: begin
        if (clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    flag_d = (state_d == ST_CAPTURED);
    to_d   = (state_d == ST_TIMEDOUT);
  end

  // State, capture and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_s1_q <= '0;
      sw_s2_q <= '0;
      state_q <= ST_IDLE;
      flag_q  <= 1'b0;
      to_q    <= 1'b0;
      fp_q    <= '0;
      swv_q   <= '0;
      win_q   <= '0;
    end else begin
      sw_s1_q <= sw_s1_d;
      sw_s2_q <= sw_s2_d;
      state_q <= state_d;
      flag_q  <= flag_d;
      to_q    <= to_d;
      fp_q    <= fp_d;
      swv_q   <= swv_d;
      win_q   <= win_d;
    end
  end

  assign playerInputFlag = flag_q;
  assign firstPlayerFlag = fp_q;
  assign switchInput     = swv_q;
  assign timeout         = to_q;
  assign state_dbg       = state_q;

endmodule
